// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath package.
// Holds the default operand geometry used by the pipelined adder/subtractor
// family and the default-geometry stage record layouts.
//   WIDTH_DEF : default operand width
//   SPLIT_DEF : default lower-slice width
//   s1_t      : stage-1 record {lo, b1, a_hi, b_hi}
//   s2_t      : stage-2 record {diff, ovf}
package arith_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int SPLIT_DEF = 32;
    localparam int HI_DEF    = WIDTH_DEF - SPLIT_DEF;

    typedef struct packed {
        logic [SPLIT_DEF-1:0] lo;
        logic                 b1;
        logic [HI_DEF-1:0]    a_hi;
        logic [HI_DEF-1:0]    b_hi;
    } s1_t;

    typedef struct packed {
        logic [WIDTH_DEF:0] diff;
        logic               ovf;
    } s2_t;

endpackage

// File: rtl/subtractor_pipelined_if.sv
// Handshake/bus bundle for subtractor_pipelined.
//   in_valid/in_ready/A/B        : operand channel (master -> slave)
//   out_valid/out_ready/FinalDiff/ovf : result channel (slave -> master)
// master = traffic source/sink, slave = the subtractor.
interface subtractor_pipelined_if
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   FinalDiff;
    logic             ovf;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, FinalDiff, ovf
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, FinalDiff, ovf
    );
endinterface

// File: rtl/sub_slice.sv
// Parametric-width subtract slice: {bout, d} = a - b - bin.
//   a, b : W-bit operands
//   bin  : borrow in
//   d    : W-bit difference
//   bout : borrow out (1 when a < b + bin, unsigned)
module sub_slice
    import arith_pkg::*;
#(
    parameter int W = SPLIT_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);
    // One extra bit: a negative true result shows up as a set MSB (the borrow).
    logic [W:0] full_s;

    assign full_s    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    assign {bout, d} = full_s;
endmodule

// File: rtl/subtractor_pipelined.sv
// Two-stage pipelined subtractor with valid/ready flow control.
// Stage 1 subtracts the lower SPLIT bits and registers the borrow with the
// upper operands; stage 2 finishes the upper slice and registers the result.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of subtractor_pipelined_if (operands in, result out)
module subtractor_pipelined
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SPLIT = SPLIT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    subtractor_pipelined_if.slave  bus
);
    localparam int HI_W = WIDTH - SPLIT;

    typedef struct packed {
        logic [SPLIT-1:0] lo;
        logic             b1;
        logic [HI_W-1:0]  a_hi;
        logic [HI_W-1:0]  b_hi;
    } stage1_t;

    typedef struct packed {
        logic [WIDTH:0] diff;
        logic           ovf;
    } stage2_t;

    stage1_t          s1_q, s1_d, s1_new_s;
    stage2_t          s2_q, s2_d, s2_new_s;
    logic             v1_q, v1_d, v2_q, v2_d;
    logic             adv1_s, adv2_s;
    logic [SPLIT-1:0] lo_s;
    logic             b1_s;
    logic [HI_W-1:0]  hi_s;
    logic             bout_s;

    sub_slice #(.W(SPLIT)) u_lo (
        .a    (bus.A[SPLIT-1:0]),
        .b    (bus.B[SPLIT-1:0]),
        .bin  (1'b0),
        .d    (lo_s),
        .bout (b1_s)
    );

    // Upper slice consumes the borrow that travelled with its own operands.
    sub_slice #(.W(HI_W)) u_hi (
        .a    (s1_q.a_hi),
        .b    (s1_q.b_hi),
        .bin  (s1_q.b1),
        .d    (hi_s),
        .bout (bout_s)
    );

    // A stage may move when it is empty or the stage after it is moving.
    assign adv2_s       = ~v2_q | bus.out_ready;
    assign adv1_s       = ~v1_q | adv2_s;
    assign bus.in_ready = reset & adv1_s;

    assign bus.out_valid = v2_q;
    assign bus.FinalDiff = s2_q.diff;
    assign bus.ovf       = s2_q.ovf;

    // Assemble the records that each stage would capture this cycle.
    always_comb begin
        s1_new_s      = '0;
        s1_new_s.lo   = lo_s;
        s1_new_s.b1   = b1_s;
        s1_new_s.a_hi = bus.A[WIDTH-1:SPLIT];
        s1_new_s.b_hi = bus.B[WIDTH-1:SPLIT];

        s2_new_s      = '0;
        s2_new_s.diff = {bout_s, hi_s, s1_q.lo};
        // Overflow only possible when operand signs differ and the result sign
        // disagrees with the minuend.
        s2_new_s.ovf  = (s1_q.a_hi[HI_W-1] ^ s1_q.b_hi[HI_W-1]) &
                        (hi_s[HI_W-1] ^ s1_q.a_hi[HI_W-1]);
    end

    // Next-state for both stages: load when advancing with valid data, else hold.
    always_comb begin
        v1_d = v1_q;
        s1_d = s1_q;
        v2_d = v2_q;
        s2_d = s2_q;
        if (adv1_s) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d = s1_new_s;
            end else begin
                s1_d = s1_q;
            end
        end else begin
            v1_d = v1_q;
        end
        if (adv2_s) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_d = s2_new_s;
            end else begin
                s2_d = s2_q;
            end
        end else begin
            v2_d = v2_q;
        end
    end

    // Pipeline registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end
endmodule

// File: tb/tb_subtractor_pipelined.sv
module tb_subtractor_pipelined;
    import arith_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] va [0:13];
    logic [63:0] vb [0:13];

    subtractor_pipelined_if #(.WIDTH(WIDTH_DEF)) bus ();

    subtractor_pipelined #(.WIDTH(WIDTH_DEF), .SPLIT(SPLIT_DEF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] ref_diff(input logic [63:0] a, input logic [63:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic ref_ovf(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] d;
        d = a - b;
        return (a[63] != b[63]) && (d[63] != a[63]);
    endfunction

    // Single transaction on an empty pipe; checks latency and result.
    task automatic send_chk(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [64:0] exp_d, input logic exp_o);
        bus.in_valid  = 1'b1;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 65'(bus.in_ready), 65'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk({tag, "_valid_early"}, 65'(bus.out_valid), 65'd0);
        @(negedge clk);
        #1;
        chk({tag, "_valid_at_2"}, 65'(bus.out_valid), 65'd1);
        chk({tag, "_diff"}, bus.FinalDiff, exp_d);
        chk({tag, "_ovf"}, 65'(bus.ovf), 65'(exp_o));
        @(negedge clk);
    endtask

    // Streams n vectors from the table; optional 3-cycle stall after first result.
    task automatic run_stream(input string tag, input int base, input int n, input bit do_stall);
        logic [64:0] exp_q [$];
        logic        exp_o_q [$];
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int stall_left = 0;
        bit stalled = 1'b0;
        bit saw_block = 1'b0;
        while (got < n && cyc < 200) begin
            bus.out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            bus.in_valid = (idx < n);
            bus.A = (idx < n) ? va[base + idx] : 64'd0;
            bus.B = (idx < n) ? vb[base + idx] : 64'd0;
            #1;
            if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_spurious"}, 65'(bus.out_valid), 65'd0);
                end else begin
                    chk({tag, "_diff"}, bus.FinalDiff, exp_q[0]);
                    chk({tag, "_ovf"}, 65'(bus.ovf), 65'(exp_o_q[0]));
                    if (bus.out_ready) begin
                        if (!do_stall) chk({tag, "_cycle"}, 65'(cyc), 65'(2 + got));
                        void'(exp_q.pop_front());
                        void'(exp_o_q.pop_front());
                        got++;
                        if (do_stall && !stalled) begin
                            stall_left = 3;
                            stalled = 1'b1;
                        end
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_diff(va[base + idx], vb[base + idx]));
                exp_o_q.push_back(ref_ovf(va[base + idx], vb[base + idx]));
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_count"}, 65'(got), 65'(n));
        if (do_stall) chk({tag, "_in_ready_fell"}, 65'(saw_block), 65'd1);
        bus.in_valid = 1'b0;
        #1;
        chk({tag, "_drained"}, 65'(bus.out_valid), 65'd0);
        @(negedge clk);
    endtask

    initial begin
        va = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
               64'h0000_0000_8000_0000, 64'hDEAD_BEEF_0000_0000, 64'h1111_1111_1111_1111,
               64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0001_0000_0000,
               64'h1234_0000_FFFF_0000, 64'hFFFF_0000_0000_FFFF, 64'h0000_0000_0000_0005,
               64'h8000_0000_0000_0001, 64'h5555_5555_AAAA_AAAA};
        vb = '{64'h0FED_CBA9_8765_4321, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0000_0000_8000_0001, 64'h0000_0000_CAFE_F00D, 64'h1111_1111_1111_1111,
               64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001,
               64'h0000_1234_0000_FFFF, 64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0000_0007,
               64'h0000_0000_0000_0002, 64'hAAAA_AAAA_5555_5555};
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = 64'd0;
        bus.B         = 64'd0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 65'(bus.out_valid), 65'd0);
        chk("rst_diff", bus.FinalDiff, 65'd0);
        chk("rst_ovf", 65'(bus.ovf), 65'd0);
        chk("rst_in_ready", 65'(bus.in_ready), 65'd0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", 65'(bus.in_ready), 65'd1);
        @(negedge clk);

        // Directed corner cases
        send_chk("xborrow", 64'h0000_0001_0000_0000, 64'h1, 65'h0_0000_0000_FFFF_FFFF, 1'b0);
        send_chk("underflow", 64'h0, 64'h1, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b0);
        send_chk("sovf", 64'h8000_0000_0000_0000, 64'h1, 65'h0_7FFF_FFFF_FFFF_FFFF, 1'b1);
        send_chk("posovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 65'h1_8000_0000_0000_0000, 1'b1);

        // Throughput and backpressure
        run_stream("tp", 0, 8, 1'b0);
        run_stream("bp", 8, 6, 1'b1);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.A         = va[0];
        bus.B         = vb[0];
        @(negedge clk);
        bus.A = va[1];
        bus.B = vb[1];
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("full_in_ready", 65'(bus.in_ready), 65'd0);
        chk("full_out_valid", 65'(bus.out_valid), 65'd1);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", 65'(bus.out_valid), 65'd0);
        chk("mid_rst_diff", bus.FinalDiff, 65'd0);
        chk("mid_rst_ovf", 65'(bus.ovf), 65'd0);
        chk("mid_rst_in_ready", 65'(bus.in_ready), 65'd0);
        reset = 1'b1;
        #1;
        chk("mid_rel_in_ready", 65'(bus.in_ready), 65'd1);
        send_chk("after_rst", 64'd5, 64'd3, 65'd2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
